ec_jacobian_to_affine: RTL and testbench

- Converts a Jacobian-coordinate point (X, Y, Z) over GF(p), as produced by the point-addition core, back to affine form: x = X·Z⁻² mod p, y = Y·Z⁻³ mod p.
- Sits on the output side of the point-addition datapath and consumes its X3/Y3/Z3 results.
- Uses one binary-extended-Euclid inverter and one bit-serial interleaved modular multiplier, sequenced by an FSM.

---
 rtl/ec_jacobian_to_affine_if.sv | 26 ++
 rtl/ec_jacobian_to_affine.sv | 208 ++++++++++++++++++++
 tb/tb_ec_jacobian_to_affine.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ec_jacobian_to_affine_if.sv
// Start/operand/result bundle between the point-addition output stage and the
// Jacobian-to-affine converter.
interface ec_jacobian_to_affine_if #(
  parameter int unsigned WIDTH = 256
);
  logic             i_start;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] Z;
  logic [WIDTH-1:0] x_a;
  logic [WIDTH-1:0] y_a;
  logic             o_inf;
  logic             o_busy;
  logic             o_done;

  modport master (
    output i_start, p, X, Y, Z,
    input  x_a, y_a, o_inf, o_busy, o_done
  );

  modport slave (
    input  i_start, p, X, Y, Z,
    output x_a, y_a, o_inf, o_busy, o_done
  );
endinterface

// File: rtl/ec_jacobian_to_affine.sv
// Jacobian (X, Y, Z) to affine (X/Z^2, Y/Z^3) over GF(p): one binary
// extended-Euclid inverter followed by four bit-serial modular multiplies.
module ec_jacobian_to_affine #(
  parameter int unsigned WIDTH = 256
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  ec_jacobian_to_affine_if.slave  bus
);
  localparam int unsigned INV_LIMIT = 4 * WIDTH + 4;
  localparam int unsigned IW        = $clog2(INV_LIMIT + 1);
  localparam int unsigned BW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INV,
    S_MUL_ZI2,
    S_MUL_X,
    S_MUL_ZI3,
    S_MUL_Y,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  // Operands latched at start
  logic [WIDTH-1:0] p_r, x_r, y_r;
  logic             inf_r;

  // Inverter state
  logic [WIDTH-1:0] u, v, r1, r2;
  logic [IW-1:0]    inv_cnt;

  // Multiplier state and intermediate results
  logic [WIDTH-1:0] mul_a, mul_b, acc;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] zi, zi2, x_res, y_res;

  // Combinational datapath
  logic [WIDTH:0]   p_ext;
  logic [WIDTH:0]   r1_sum, r2_sum;
  logic [WIDTH-1:0] r1_half, r2_half, r1_sub, r2_sub;
  logic [WIDTH:0]   dbl, dbl_red, add_sum;
  logic [WIDTH-1:0] acc_nxt, zi_sel;
  logic             inv_u_one, inv_v_one, inv_timeout, mul_last;

  // Modular halving/subtraction for the inverter and one MSB-first multiply step
  always_comb begin
    p_ext       = {1'b0, p_r};
    r1_sum      = {1'b0, r1} + (r1[0] ? p_ext : '0);
    r2_sum      = {1'b0, r2} + (r2[0] ? p_ext : '0);
    r1_half     = WIDTH'(r1_sum >> 1);
    r2_half     = WIDTH'(r2_sum >> 1);
    r1_sub      = (r1 >= r2) ? (r1 - r2) : (r1 - r2 + p_r);
    r2_sub      = (r2 >= r1) ? (r2 - r1) : (r2 - r1 + p_r);
    dbl         = {acc, 1'b0};
    dbl_red     = (dbl >= p_ext) ? (dbl - p_ext) : dbl;
    add_sum     = dbl_red + (mul_b[WIDTH-1] ? {1'b0, mul_a} : '0);
    acc_nxt     = WIDTH'((add_sum >= p_ext) ? (add_sum - p_ext) : add_sum);
    inv_u_one   = (u == WIDTH'(1));
    inv_v_one   = (v == WIDTH'(1));
    zi_sel      = inv_u_one ? r1 : r2;
    inv_timeout = (inv_cnt == IW'(INV_LIMIT - 1));
    mul_last    = (bit_cnt == BW'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (bus.i_start) state_nxt = (bus.Z == '0) ? S_DONE : S_INV;
      S_INV: begin
        if (inv_u_one || inv_v_one) state_nxt = S_MUL_ZI2;
        else if (inv_timeout)       state_nxt = S_DONE;
      end
      S_MUL_ZI2: if (mul_last) state_nxt = S_MUL_X;
      S_MUL_X:   if (mul_last) state_nxt = S_MUL_ZI3;
      S_MUL_ZI3: if (mul_last) state_nxt = S_MUL_Y;
      S_MUL_Y:   if (mul_last) state_nxt = S_DONE;
      S_DONE:    if (bus.o_done && !bus.i_start) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      p_r        <= '0;
      x_r        <= '0;
      y_r        <= '0;
      inf_r      <= 1'b0;
      u          <= '0;
      v          <= '0;
      r1         <= '0;
      r2         <= '0;
      inv_cnt    <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      acc        <= '0;
      bit_cnt    <= '0;
      zi         <= '0;
      zi2        <= '0;
      x_res      <= '0;
      y_res      <= '0;
      bus.x_a    <= '0;
      bus.y_a    <= '0;
      bus.o_inf  <= 1'b0;
      bus.o_busy <= 1'b0;
      bus.o_done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.i_start) begin
            p_r        <= bus.p;
            x_r        <= bus.X;
            y_r        <= bus.Y;
            inf_r      <= (bus.Z == '0);
            u          <= bus.Z;
            v          <= bus.p;
            r1         <= WIDTH'(1);
            r2         <= '0;
            inv_cnt    <= '0;
            x_res      <= '0;
            y_res      <= '0;
            bus.o_busy <= 1'b1;
            bus.o_done <= 1'b0;
            bus.o_inf  <= 1'b0;
          end
        end

        S_INV: begin
          if (inv_u_one || inv_v_one) begin
            zi      <= zi_sel;
            mul_a   <= zi_sel;
            mul_b   <= zi_sel;
            acc     <= '0;
            bit_cnt <= '0;
          end else if (!inv_timeout) begin
            inv_cnt <= inv_cnt + IW'(1);
            if (!u[0]) begin
              u  <= u >> 1;
              r1 <= r1_half;
            end else if (!v[0]) begin
              v  <= v >> 1;
              r2 <= r2_half;
            end else if (u >= v) begin
              u  <= u - v;
              r1 <= r1_sub;
            end else begin
              v  <= v - u;
              r2 <= r2_sub;
            end
          end
        end

        S_MUL_ZI2, S_MUL_X, S_MUL_ZI3, S_MUL_Y: begin
          if (!mul_last) begin
            acc     <= acc_nxt;
            mul_b   <= {mul_b[WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt + BW'(1);
          end else begin
            acc     <= '0;
            bit_cnt <= '0;
            // Chain the finished product into the next multiply's operands
            case (state)
              S_MUL_ZI2: begin
                zi2   <= acc_nxt;
                mul_a <= x_r;
                mul_b <= acc_nxt;
              end
              S_MUL_X: begin
                x_res <= acc_nxt;
                mul_a <= zi2;
                mul_b <= zi;
              end
              S_MUL_ZI3: begin
                mul_a <= y_r;
                mul_b <= acc_nxt;
              end
              default: y_res <= acc_nxt;
            endcase
          end
        end

        S_DONE: begin
          // First DONE cycle publishes; later cycles wait for start to drop
          if (!bus.o_done) begin
            bus.x_a    <= x_res;
            bus.y_a    <= y_res;
            bus.o_inf  <= inf_r;
            bus.o_busy <= 1'b0;
            bus.o_done <= 1'b1;
          end else if (!bus.i_start) begin
            bus.o_done <= 1'b0;
          end
        end

        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ec_jacobian_to_affine.sv
// Bench for ec_jacobian_to_affine: known-answer table, randomized vectors
// against a Fermat-inverse reference model, and reset/latching sequences.
module tb_ec_jacobian_to_affine;
  localparam int unsigned W      = 256;
  localparam int unsigned BUDGET = 9 * W + 16;

  typedef logic [W-1:0]   word_t;
  typedef logic [2*W-1:0] dword_t;

  typedef struct {
    string name;
    word_t p;
    word_t x;
    word_t y;
    word_t z;
    word_t ex;
    word_t ey;
    logic  einf;
  } vec_t;

  localparam word_t SECP_P  = 256'hfffffffffffffffffffffffffffffffffffffffffffffffffffffffefffffc2f;
  localparam word_t SECP_GX = 256'h79be667ef9dcbbac55a06295ce870b07029bfcdb2dce28d959f2815b16f81798;
  localparam word_t SECP_GY = 256'h483ada7726a3c4655da4fbfc0e1108a8fd17b448a68554199c47d08ffb10d4b8;
  localparam word_t M127    = 256'h7fffffffffffffffffffffffffffffff;

  logic i_clk = 1'b0;
  logic i_rst_n;

  ec_jacobian_to_affine_if #(.WIDTH(W)) bus ();

  ec_jacobian_to_affine #(.WIDTH(W)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference arithmetic: wide products reduced with %, inverse by Fermat
  function automatic word_t mulmod(input word_t a, input word_t b, input word_t m);
    dword_t prod;
    prod = dword_t'(a) * dword_t'(b);
    return word_t'(prod % dword_t'(m));
  endfunction

  function automatic word_t invmod(input word_t a, input word_t m);
    word_t r, e;
    r = word_t'(1);
    e = m - word_t'(2);
    for (int i = W - 1; i >= 0; i--) begin
      r = mulmod(r, r, m);
      if (e[i]) r = mulmod(r, a, m);
    end
    return r;
  endfunction

  function automatic vec_t mk(input string n, input word_t p, input word_t x, input word_t y,
                              input word_t z, input word_t ex, input word_t ey, input logic inf);
    vec_t t;
    t.name = n; t.p = p; t.x = x; t.y = y; t.z = z; t.ex = ex; t.ey = ey; t.einf = inf;
    return t;
  endfunction

  function automatic word_t rand_word();
    word_t w;
    for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // One full conversion with start held through DONE, then start dropped
  task automatic run_conv(input word_t vp, input word_t vx, input word_t vy, input word_t vz,
                          output word_t rx, output word_t ry, output logic rinf,
                          output int cyc, output bit held, output int drop);
    @(negedge i_clk);
    bus.p = vp; bus.X = vx; bus.Y = vy; bus.Z = vz; bus.i_start = 1'b1;
    cyc = 0;
    do begin
      @(negedge i_clk);
      cyc++;
    end while (!bus.o_done && cyc < BUDGET);
    rx   = bus.x_a;
    ry   = bus.y_a;
    rinf = bus.o_inf;
    held = bus.o_done;
    repeat (3) begin
      @(negedge i_clk);
      held &= bus.o_done;
    end
    bus.i_start = 1'b0;
    drop = 0;
    do begin
      @(negedge i_clk);
      drop++;
    end while (bus.o_done && drop < 8);
  endtask

  initial begin
    vec_t  tbl[5];
    word_t rx, ry, k, k2, vp, vx, vy, vz, zi, ex, ey;
    logic  rinf;
    int    cyc, drop, wait_cyc;
    bit    held;
    word_t primes[4];

    primes[0] = word_t'(23);
    primes[1] = word_t'(65537);
    primes[2] = M127;
    primes[3] = SECP_P;

    // secp256k1 generator lifted to Jacobian form with a fixed Z
    k  = 256'h3b7f1a2c9d4e5f60718293a4b5c6d7e8f90a1b2c3d4e5f60718293a4b5c6d7e8;
    k2 = mulmod(k, k, SECP_P);
    tbl[0] = mk("z_one",  word_t'(23), word_t'(5),  word_t'(17), word_t'(1),  word_t'(5), word_t'(17), 1'b0);
    tbl[1] = mk("z_two",  word_t'(23), word_t'(20), word_t'(8),  word_t'(2),  word_t'(5), word_t'(1),  1'b0);
    tbl[2] = mk("z_neg1", word_t'(23), word_t'(5),  word_t'(17), word_t'(22), word_t'(5), word_t'(6),  1'b0);
    tbl[3] = mk("z_zero", word_t'(23), word_t'(5),  word_t'(17), word_t'(0),  word_t'(0), word_t'(0),  1'b1);
    tbl[4] = mk("secp", SECP_P, mulmod(SECP_GX, k2, SECP_P),
                mulmod(SECP_GY, mulmod(k2, k, SECP_P), SECP_P), k, SECP_GX, SECP_GY, 1'b0);

    i_rst_n = 1'b0;
    bus.i_start = 1'b0; bus.p = '0; bus.X = '0; bus.Y = '0; bus.Z = '0;
    repeat (3) @(negedge i_clk);
    chk("rst_busy", word_t'(bus.o_busy), word_t'(0));
    chk("rst_done", word_t'(bus.o_done), word_t'(0));
    chk("rst_inf",  word_t'(bus.o_inf),  word_t'(0));
    chk("rst_x_a",  bus.x_a, word_t'(0));
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Known-answer table
    for (int i = 0; i < 5; i++) begin
      run_conv(tbl[i].p, tbl[i].x, tbl[i].y, tbl[i].z, rx, ry, rinf, cyc, held, drop);
      chk({tbl[i].name, "_done_held"}, word_t'(held), word_t'(1));
      chk({tbl[i].name, "_x"},   rx, tbl[i].ex);
      chk({tbl[i].name, "_y"},   ry, tbl[i].ey);
      chk({tbl[i].name, "_inf"}, word_t'(rinf), word_t'(tbl[i].einf));
      chk({tbl[i].name, "_drop"}, word_t'(drop), word_t'(1));
      if (tbl[i].z == '0) chk({tbl[i].name, "_latency"}, word_t'(cyc), word_t'(2));
      if (tbl[i].p == SECP_P) begin
        chk("secp_latency_ok", word_t'(cyc <= int'(8 * W + 2)), word_t'(1));
        chk("secp_sb_x", mulmod(rx, k2, SECP_P), tbl[i].x);
        chk("secp_sb_y", mulmod(ry, mulmod(k2, k, SECP_P), SECP_P), tbl[i].y);
      end
    end

    // Randomized vectors against the Fermat-inverse model
    for (int i = 0; i < 8; i++) begin
      vp = primes[i % 4];
      vx = rand_word() % vp;
      vy = rand_word() % vp;
      vz = rand_word() % vp;
      if (vz == '0) begin
        ex = '0; ey = '0;
      end else begin
        zi = invmod(vz, vp);
        ex = mulmod(vx, mulmod(zi, zi, vp), vp);
        ey = mulmod(vy, mulmod(mulmod(zi, zi, vp), zi, vp), vp);
      end
      run_conv(vp, vx, vy, vz, rx, ry, rinf, cyc, held, drop);
      chk($sformatf("rand%0d_done", i), word_t'(held), word_t'(1));
      chk($sformatf("rand%0d_x", i), rx, ex);
      chk($sformatf("rand%0d_y", i), ry, ey);
      chk($sformatf("rand%0d_inf", i), word_t'(rinf), word_t'(vz == '0));
    end

    // Reset in the middle of MUL_X aborts and clears everything at once
    @(negedge i_clk);
    bus.p = word_t'(23); bus.X = word_t'(20); bus.Y = word_t'(8); bus.Z = word_t'(2);
    bus.i_start = 1'b1;
    repeat (400) @(negedge i_clk);
    chk("mid_busy", word_t'(bus.o_busy), word_t'(1));
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_busy", word_t'(bus.o_busy), word_t'(0));
    chk("arst_done", word_t'(bus.o_done), word_t'(0));
    chk("arst_x_a",  bus.x_a, word_t'(0));
    chk("arst_y_a",  bus.y_a, word_t'(0));
    bus.i_start = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Restart; operand inputs change mid-run and must not matter
    bus.p = word_t'(23); bus.X = word_t'(20); bus.Y = word_t'(8); bus.Z = word_t'(2);
    bus.i_start = 1'b1;
    repeat (40) @(negedge i_clk);
    bus.p = word_t'(29); bus.X = word_t'(7); bus.Y = word_t'(3); bus.Z = word_t'(5);
    wait_cyc = 40;
    while (!bus.o_done && wait_cyc < int'(BUDGET)) begin
      @(negedge i_clk);
      wait_cyc++;
    end
    chk("restart_done", word_t'(bus.o_done), word_t'(1));
    chk("restart_x", bus.x_a, word_t'(5));
    chk("restart_y", bus.y_a, word_t'(1));
    bus.i_start = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("restart_idle_done", word_t'(bus.o_done), word_t'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
